cnn_layer_scheduler: RTL and testbench
======================================

CNN_LAYER_SCHEDULER -- requirements
Module: cnn_layer_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd1000000, the maximum number of cycles allowed in one RUN state.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port layer1_input_store_done  input  1  layer-1 pixel memory is loaded (level).
REQ-005 SHALL have port layer1_weight_store_done  input  1  layer-1 weights are loaded (level).
REQ-006 SHALL have port layer1_bias_store_done  input  1  layer-1 biases are loaded (level).
REQ-007 SHALL have port layer2_weight_store_done  input  1  layer-2 weights are loaded (level).
REQ-008 SHALL have port layer2_bias_store_done  input  1  layer-2 biases are loaded (level).
REQ-009 SHALL have port layer1_calculation_done  input  1  layer-1 finished (pulse).
REQ-010 SHALL have port layer2_calculation_done  input  1  layer-2 finished (pulse).
REQ-011 SHALL have port layer1_read_weight_signal  input  1  layer-1 weight read request.
REQ-012 SHALL have port layer1_read_weight_addr  input  16  layer-1 weight address.
REQ-013 SHALL have port layer1_read_bias_signal  input  1  layer-1 bias read request.
REQ-014 SHALL have port layer1_read_bias_addr  input  16  layer-1 bias address.
REQ-015 SHALL have port layer2_read_weight_signal  input  1  layer-2 weight read request.
REQ-016 SHALL have port layer2_read_weight_addr  input  16  layer-2 weight address.
REQ-017 SHALL have port layer2_read_bias_signal  input  1  layer-2 bias read request.
REQ-018 SHALL have port layer2_read_bias_addr  input  16  layer-2 bias address.
REQ-019 SHALL have port layer1_start  output  1  one-cycle start pulse to layer 1.
REQ-020 SHALL have port layer2_start  output  1  one-cycle start pulse to layer 2.
REQ-021 SHALL have port read_weight_signal_data  output  1  granted weight read strobe.
REQ-022 SHALL have port read_weight_addr_data  output  16  granted weight address.
REQ-023 SHALL have port read_bias_signal_data  output  1  granted bias read strobe.
REQ-024 SHALL have port read_bias_addr_data  output  16  granted bias address.
REQ-025 SHALL have port interrupt_register_write_signal  output  1  one-cycle pulse when the network completes.
REQ-026 SHALL have port sched_state  output  3  current FSM state encoding.

Function
REQ-027 SHALL implement the FSM states IDLE=0, L1_START=1, L1_RUN=2, L2_WAIT=3, L2_START=4, L2_RUN=5, DONE=6.
REQ-028 SHALL transition IDLE->L1_START when all three layer1_*_store_done inputs are high in the same cycle.
REQ-029 SHALL assert layer1_start for exactly the one cycle spent in L1_START, then unconditionally enter L1_RUN.
REQ-030 SHALL transition L1_RUN->L2_WAIT on layer1_calculation_done, and L2_WAIT->L2_START once layer2_weight_store_done and layer2_bias_store_done are both high.
REQ-031 SHALL treat L2_START like L1_START (layer2_start pulses for one cycle) and transition L2_RUN->DONE on layer2_calculation_done.
REQ-032 SHALL assert interrupt_register_write_signal for the single cycle in DONE, then return to IDLE.
REQ-033 SHALL grant the weight and bias ports combinationally (zero latency) to layer 1 in L1_RUN and to layer 2 in L2_RUN; in every other state the strobes and addresses SHALL be 0.
REQ-034 SHALL drop requests from the non-granted layer with no queueing and no side effects.
REQ-035 SHALL ignore a calculation_done pulse that arrives outside the matching RUN state.
REQ-036 SHALL move L1_RUN->L2_WAIT when layer1_calculation_done coincides with the L1_RUN entry cycle.

Reset
REQ-037 SHALL, on rst low, asynchronously force the state to IDLE and drive every output to 0, including in the middle of a RUN state.

Configuration
REQ-038 SHALL, with SCHED_TIMEOUT_EN defined, count cycles in each RUN state, add output port timeout_error (1 bit, sticky until reset), and go to IDLE without pulsing the interrupt when the count reaches TIMEOUT_CYCLES; without the macro, the counter and the port SHALL be absent and the RUN states SHALL have no timeout.

Structure
REQ-039 SHALL take the state enum (sched_state_t) and the state encodings from the shared package cnn_sched_pkg; it SHALL have no sub-module.

Verification
REQ-040 SHALL test: all layer-1 store_done inputs high at cycle 5 -> layer1_start=1 at cycle 6 only, sched_state=2 at cycle 7.
REQ-041 SHALL test: in L1_RUN, layer1 weight addr=16'h0010 and layer2 weight addr=16'h0020 both requested -> read_weight_addr_data=16'h0010 with strobe 1.
REQ-042 SHALL test: the full two-layer sequence -> exactly one interrupt_register_write_signal pulse, then sched_state=0.
REQ-043 SHALL test: rst low during L2_RUN -> sched_state=0 and read strobes=0 immediately, with no interrupt pulse.

Source files
------------

// File: rtl/cnn_sched_pkg.sv
// Shared types for the two-layer CNN scheduler: state encoding and address width.
// The optional RUN-state watchdog is enabled with the SCHED_TIMEOUT_EN macro.
package cnn_sched_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    L1_START = 3'd1,
    L1_RUN   = 3'd2,
    L2_WAIT  = 3'd3,
    L2_START = 3'd4,
    L2_RUN   = 3'd5,
    DONE     = 3'd6
  } sched_state_t;

  function automatic logic is_run_state(sched_state_t s);
    return (s == L1_RUN) || (s == L2_RUN);
  endfunction

endpackage

// File: rtl/cnn_layer_scheduler_if.sv
// Bundle of store-status, completion, read-request and grant signals around the scheduler.
// timeout_error exists only when SCHED_TIMEOUT_EN is defined.
interface cnn_layer_scheduler_if;
  import cnn_sched_pkg::*;

  logic              layer1_input_store_done;
  logic              layer1_weight_store_done;
  logic              layer1_bias_store_done;
  logic              layer2_weight_store_done;
  logic              layer2_bias_store_done;
  logic              layer1_calculation_done;
  logic              layer2_calculation_done;

  logic              layer1_read_weight_signal;
  logic [ADDR_W-1:0] layer1_read_weight_addr;
  logic              layer1_read_bias_signal;
  logic [ADDR_W-1:0] layer1_read_bias_addr;
  logic              layer2_read_weight_signal;
  logic [ADDR_W-1:0] layer2_read_weight_addr;
  logic              layer2_read_bias_signal;
  logic [ADDR_W-1:0] layer2_read_bias_addr;

  logic              layer1_start;
  logic              layer2_start;
  logic              read_weight_signal_data;
  logic [ADDR_W-1:0] read_weight_addr_data;
  logic              read_bias_signal_data;
  logic [ADDR_W-1:0] read_bias_addr_data;
  logic              interrupt_register_write_signal;
  logic [2:0]        sched_state;
`ifdef SCHED_TIMEOUT_EN
  logic              timeout_error;
`endif

  // Environment side: stores, layer engines and the weight/bias memories.
  modport master (
    output layer1_input_store_done, layer1_weight_store_done, layer1_bias_store_done,
    output layer2_weight_store_done, layer2_bias_store_done,
    output layer1_calculation_done, layer2_calculation_done,
    output layer1_read_weight_signal, layer1_read_weight_addr,
    output layer1_read_bias_signal, layer1_read_bias_addr,
    output layer2_read_weight_signal, layer2_read_weight_addr,
    output layer2_read_bias_signal, layer2_read_bias_addr,
    input  layer1_start, layer2_start,
    input  read_weight_signal_data, read_weight_addr_data,
    input  read_bias_signal_data, read_bias_addr_data,
    input  interrupt_register_write_signal, sched_state
`ifdef SCHED_TIMEOUT_EN
    , input timeout_error
`endif
  );

  // Scheduler side.
  modport slave (
    input  layer1_input_store_done, layer1_weight_store_done, layer1_bias_store_done,
    input  layer2_weight_store_done, layer2_bias_store_done,
    input  layer1_calculation_done, layer2_calculation_done,
    input  layer1_read_weight_signal, layer1_read_weight_addr,
    input  layer1_read_bias_signal, layer1_read_bias_addr,
    input  layer2_read_weight_signal, layer2_read_weight_addr,
    input  layer2_read_bias_signal, layer2_read_bias_addr,
    output layer1_start, layer2_start,
    output read_weight_signal_data, read_weight_addr_data,
    output read_bias_signal_data, read_bias_addr_data,
    output interrupt_register_write_signal, sched_state
`ifdef SCHED_TIMEOUT_EN
    , output timeout_error
`endif
  );

endinterface

// File: rtl/cnn_layer_scheduler.sv
// Sequences layer 1 then layer 2 of a CNN and arbitrates the shared weight/bias read ports.
// Define SCHED_TIMEOUT_EN to add a per-RUN-state watchdog and the sticky timeout_error output.
module cnn_layer_scheduler
  import cnn_sched_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input logic                  clk,
  input logic                  rst,
  cnn_layer_scheduler_if.slave bus
);

  sched_state_t state;
  logic         layer1_start_q;
  logic         layer2_start_q;
  logic         irq_q;
  logic         l1_stores_ready;
  logic         l2_stores_ready;
  logic         timeout_hit;

  assign l1_stores_ready = bus.layer1_input_store_done & bus.layer1_weight_store_done &
                           bus.layer1_bias_store_done;
  assign l2_stores_ready = bus.layer2_weight_store_done & bus.layer2_bias_store_done;

`ifdef SCHED_TIMEOUT_EN
  logic [31:0] run_cnt;
  logic        timeout_q;
  logic        run_done;

  assign run_done    = (state == L1_RUN) ? bus.layer1_calculation_done
                                         : bus.layer2_calculation_done;
  // A done pulse on the final allowed cycle still wins over the timeout.
  assign timeout_hit = is_run_state(state) && !run_done &&
                       (run_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      run_cnt <= is_run_state(state) ? run_cnt + 32'd1 : '0;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_error = timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // Start pulses and the interrupt are set on the transition into their one-cycle state,
  // so they are registered and high exactly while that state is current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      layer1_start_q <= 1'b0;
      layer2_start_q <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      layer1_start_q <= 1'b0;
      layer2_start_q <= 1'b0;
      irq_q          <= 1'b0;
      case (state)
        IDLE: begin
          if (l1_stores_ready) begin
            state          <= L1_START;
            layer1_start_q <= 1'b1;
          end
        end
        L1_START: state <= L1_RUN;
        L1_RUN: begin
          if (bus.layer1_calculation_done) state <= L2_WAIT;
          else if (timeout_hit)            state <= IDLE;
        end
        L2_WAIT: begin
          if (l2_stores_ready) begin
            state          <= L2_START;
            layer2_start_q <= 1'b1;
          end
        end
        L2_START: state <= L2_RUN;
        L2_RUN: begin
          if (bus.layer2_calculation_done) begin
            state <= DONE;
            irq_q <= 1'b1;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency grant: the RUN layer's requests pass straight through, others are dropped.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    bus.read_weight_signal_data = 1'b0;
    bus.read_weight_addr_data   = '0;
    bus.read_bias_signal_data   = 1'b0;
    bus.read_bias_addr_data     = '0;
    case (state)
      L1_RUN: begin
        bus.read_weight_signal_data = bus.layer1_read_weight_signal;
        bus.read_weight_addr_data   = bus.layer1_read_weight_addr;
        bus.read_bias_signal_data   = bus.layer1_read_bias_signal;
        bus.read_bias_addr_data     = bus.layer1_read_bias_addr;
      end
      L2_RUN: begin
        bus.read_weight_signal_data = bus.layer2_read_weight_signal;
        bus.read_weight_addr_data   = bus.layer2_read_weight_addr;
        bus.read_bias_signal_data   = bus.layer2_read_bias_signal;
        bus.read_bias_addr_data     = bus.layer2_read_bias_addr;
      end
      default: ;
    endcase
  end

  assign bus.layer1_start                    = layer1_start_q;
  assign bus.layer2_start                    = layer2_start_q;
  assign bus.interrupt_register_write_signal = irq_q;
  assign bus.sched_state                     = state;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Self-checking bench for cnn_layer_scheduler: directed phase sequence with randomized
// requests, store levels and stray done pulses, checked against a behavioural model.
module tb_cnn_layer_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   irq_pulses;

  // Request model: index 0 = L1 weight, 1 = L1 bias, 2 = L2 weight, 3 = L2 bias.
  logic [3:0]  req_sig;
  logic [15:0] req_addr [4];

  cnn_layer_scheduler_if bus ();

  cnn_layer_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.layer1_read_weight_signal = req_sig[0];
  assign bus.layer1_read_weight_addr   = req_addr[0];
  assign bus.layer1_read_bias_signal   = req_sig[1];
  assign bus.layer1_read_bias_addr     = req_addr[1];
  assign bus.layer2_read_weight_signal = req_sig[2];
  assign bus.layer2_read_weight_addr   = req_addr[2];
  assign bus.layer2_read_bias_signal   = req_sig[3];
  assign bus.layer2_read_bias_addr     = req_addr[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.interrupt_register_write_signal === 1'b1) irq_pulses++;

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs_random();
    for (int i = 0; i < 4; i++) begin
      req_sig[i]  = 1'($urandom_range(0, 1));
      req_addr[i] = 16'($urandom);
    end
  endtask

  task automatic set_l1_stores(logic [2:0] v);
    bus.layer1_input_store_done  = v[0];
    bus.layer1_weight_store_done = v[1];
    bus.layer1_bias_store_done   = v[2];
  endtask

  task automatic set_l2_stores(logic [1:0] v);
    bus.layer2_weight_store_done = v[0];
    bus.layer2_bias_store_done   = v[1];
  endtask

  // Expected outputs for a given phase number: pulses are high only in their own phase,
  // and only the running layer (phase 2 -> layer 1, phase 5 -> layer 2) reaches the ports.
  task automatic check_all(string tag, int exp_phase);
    int          base;
    logic        exp_ws, exp_bs;
    logic [15:0] exp_wa, exp_ba;
    #1;
    base   = (exp_phase == 2) ? 0 : (exp_phase == 5) ? 2 : -1;
    exp_ws = 1'b0;
    exp_bs = 1'b0;
    exp_wa = 16'h0;
    exp_ba = 16'h0;
    if (base >= 0) begin
      exp_ws = req_sig[base];
      exp_wa = req_addr[base];
      exp_bs = req_sig[base + 1];
      exp_ba = req_addr[base + 1];
    end
    check({tag, ".state"}, bus.sched_state, exp_phase);
    check({tag, ".l1_start"}, bus.layer1_start, exp_phase == 1);
    check({tag, ".l2_start"}, bus.layer2_start, exp_phase == 4);
    check({tag, ".irq"}, bus.interrupt_register_write_signal, exp_phase == 6);
    check({tag, ".w_sig"}, bus.read_weight_signal_data, exp_ws);
    check({tag, ".w_addr"}, bus.read_weight_addr_data, exp_wa);
    check({tag, ".b_sig"}, bus.read_bias_signal_data, exp_bs);
    check({tag, ".b_addr"}, bus.read_bias_addr_data, exp_ba);
  endtask

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    irq_pulses = 0;
    rst        = 1'b0;
    set_l1_stores(3'b111);
    set_l2_stores(2'b11);
    bus.layer1_calculation_done = 1'b1;
    bus.layer2_calculation_done = 1'b1;
    drive_reqs_random();

    // Held in reset with every trigger asserted: nothing may move.
    #3;
    check_all("in_reset", 0);
    step();
    step();
    check_all("in_reset_clocked", 0);
    check("in_reset.irq_count", irq_pulses, 0);

    set_l1_stores(3'b000);
    set_l2_stores(2'b00);
    bus.layer1_calculation_done = 1'b0;
    bus.layer2_calculation_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Cycles 1..7: partial store sets are ignored, full set at cycle 5.
    for (int c = 1; c <= 7; c++) begin
      step();
      drive_reqs_random();
      if (c < 5)       set_l1_stores(3'($urandom_range(0, 6)));
      else if (c == 5) set_l1_stores(3'b111);
      else             set_l1_stores(3'b000);
      check_all($sformatf("cycle%0d", c), (c <= 5) ? 0 : (c == 6) ? 1 : 2);
    end

    // Both layers request weights in L1_RUN; layer 1 must win.
    req_sig     = 4'b0101;
    req_addr[0] = 16'h0010;
    req_addr[2] = 16'h0020;
    #1;
    check("l1_grant.w_addr", bus.read_weight_addr_data, 16'h0010);
    check("l1_grant.w_sig", bus.read_weight_signal_data, 1'b1);

    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) begin
      step();
      drive_reqs_random();
      bus.layer2_calculation_done = 1'($urandom_range(0, 1));
      check_all("l1_run", 2);
    end
    step();
    bus.layer2_calculation_done = 1'b0;
    bus.layer1_calculation_done = 1'b1;
    check_all("l1_done", 2);
    step();
    bus.layer1_calculation_done = 1'b0;
    check_all("l2_wait_entry", 3);

    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) begin
      step();
      drive_reqs_random();
      set_l2_stores(2'($urandom_range(0, 2)));
      bus.layer1_calculation_done = 1'($urandom_range(0, 1));
      bus.layer2_calculation_done = 1'($urandom_range(0, 1));
      check_all("l2_wait", 3);
    end
    step();
    bus.layer1_calculation_done = 1'b0;
    bus.layer2_calculation_done = 1'b0;
    set_l2_stores(2'b11);
    check_all("l2_stores_ready", 3);
    step();
    check_all("l2_start", 4);
    step();
    check_all("l2_run_entry", 5);

    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) begin
      step();
      drive_reqs_random();
      bus.layer1_calculation_done = 1'($urandom_range(0, 1));
      check_all("l2_run", 5);
    end
    step();
    bus.layer1_calculation_done = 1'b0;
    bus.layer2_calculation_done = 1'b1;
    check_all("l2_done", 5);
    step();
    bus.layer2_calculation_done = 1'b0;
    check_all("done", 6);
    step();
    check_all("back_to_idle", 0);
    check("run1.irq_count", irq_pulses, 1);

    // Second network: layer-1 done lands on the first L1_RUN cycle.
    step();
    set_l1_stores(3'b111);
    check_all("run2.idle", 0);
    step();
    set_l1_stores(3'b000);
    check_all("run2.l1_start", 1);
    step();
    bus.layer1_calculation_done = 1'b1;
    check_all("run2.l1_run_entry_done", 2);
    step();
    bus.layer1_calculation_done = 1'b0;
    check_all("run2.l2_wait", 3);
    step();
    check_all("run2.l2_start", 4);
    step();
    req_sig = 4'b1111;
    check_all("run2.l2_run", 5);

    // Asynchronous reset in the middle of L2_RUN, with the layer-2 done pending.
    #1;
    rst = 1'b0;
    bus.layer2_calculation_done = 1'b1;
    check_all("rst_mid_l2_run", 0);
    step();
    step();
    check_all("rst_held", 0);
    check("rst.irq_count", irq_pulses, 1);
    bus.layer2_calculation_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    check_all("after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
